// File: rtl/tvip_axi_sram_slave_if.sv
// AXI4 channel bundle between the SRAM responder and whatever drives it.
// Handshake rule on every channel: a transfer happens on the rising aclk edge where
// valid and ready are both 1. The source holds valid and payload stable until that edge.
interface tvip_axi_sram_slave_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  awvalid;
  logic                  awready;
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;

  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BYTES-1:0]      wstrb;
  logic                  wlast;

  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;

  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;

  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );
endinterface

// File: rtl/tvip_axi_sram_slave.sv
// AXI4 responder backed by a register-array memory; one write burst and one read
// burst in flight at a time, on independent paths. FIXED/INCR only, others get SLVERR.
module tvip_axi_sram_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 256
) (
  input  logic                aclk,
  input  logic                areset_n,
  tvip_axi_sram_slave_if.slave axi,
  output logic [1:0]          dbg_wr_state_o,
  output logic                dbg_rd_state_o
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int ALSB  = $clog2(BYTES);
  localparam int WIDX  = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b10) || (burst == 2'b11) || (size > 3'(ALSB));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    return (burst == 2'b00) ? addr : addr + (ADDR_WIDTH'(1) << size);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Holds both ready outputs low until the first edge after reset release.
  logic run_q;
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) run_q <= 1'b0;
    else           run_q <= 1'b1;
  end

  // ---------------- write path ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q, w_cnt_q;
  logic [2:0]            w_size_q;
  logic [1:0]            w_burst_q;
  logic                  w_err_q;
  logic                  aw_hs, w_hs, b_hs;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid  && axi.wready;
  assign b_hs  = axi.bvalid  && axi.bready;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) w_state_q <= W_IDLE;
    else           w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && (w_cnt_q == w_len_q)) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    axi.awready = run_q && (w_state_q == W_IDLE);
    axi.wready  = (w_state_q == W_DATA);
    axi.bvalid  = (w_state_q == W_RESP);
    axi.bid     = w_id_q;
    axi.bresp   = ((w_state_q == W_RESP) && w_err_q) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
    end else if (aw_hs) begin
      w_id_q    <= axi.awid;
      w_addr_q  <= axi.awaddr;
      w_len_q   <= axi.awlen;
      w_cnt_q   <= '0;
      w_size_q  <= axi.awsize;
      w_burst_q <= axi.awburst;
      w_err_q   <= burst_err(axi.awburst, axi.awsize);
    end else if (w_hs) begin
      // A misplaced wlast poisons the response but never ends the burst early.
      if (axi.wlast != (w_cnt_q == w_len_q)) w_err_q <= 1'b1;
      if (w_cnt_q != w_len_q) begin
        w_cnt_q  <= w_cnt_q + 8'd1;
        w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hs && !w_err_q) begin
      for (int b = 0; b < BYTES; b++) begin
        if (axi.wstrb[b]) mem[w_addr_q[ALSB +: WIDX]][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_nxt;
  logic [7:0]            r_len_q, r_cnt_q;
  logic [2:0]            r_size_q;
  logic [1:0]            r_burst_q;
  logic                  r_err_q, ar_err;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic                  ar_hs, r_hs;

  assign ar_hs      = axi.arvalid && axi.arready;
  assign r_hs       = axi.rvalid  && axi.rready;
  assign ar_err     = burst_err(axi.arburst, axi.arsize);
  assign r_addr_nxt = next_addr(r_addr_q, r_size_q, r_burst_q);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_state_q <= R_IDLE;
    else           r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs && (r_cnt_q == r_len_q)) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    axi.arready = run_q && (r_state_q == R_IDLE);
    axi.rvalid  = (r_state_q == R_DATA);
    axi.rid     = r_id_q;
    axi.rdata   = r_data_q;
    axi.rresp   = ((r_state_q == R_DATA) && r_err_q) ? 2'b10 : 2'b00;
    axi.rlast   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
  end

  // rdata is captured when a beat is loaded, so a same-edge write is not visible.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      r_data_q  <= '0;
    end else if (ar_hs) begin
      r_id_q    <= axi.arid;
      r_addr_q  <= axi.araddr;
      r_len_q   <= axi.arlen;
      r_cnt_q   <= '0;
      r_size_q  <= axi.arsize;
      r_burst_q <= axi.arburst;
      r_err_q   <= ar_err;
      r_data_q  <= ar_err ? '0 : mem[axi.araddr[ALSB +: WIDX]];
    end else if (r_hs && (r_cnt_q != r_len_q)) begin
      r_cnt_q  <= r_cnt_q + 8'd1;
      r_addr_q <= r_addr_nxt;
      r_data_q <= r_err_q ? '0 : mem[r_addr_nxt[ALSB +: WIDX]];
    end
  end

  assign dbg_wr_state_o = w_state_q;
  assign dbg_rd_state_o = r_state_q;
endmodule

// File: tb/tb_tvip_axi_sram_slave.sv
// Self-checking bench for tvip_axi_sram_slave: directed AXI bursts plus a few random
// ones, with read data checked against a byte-accurate memory model via exp_q.
module tb_tvip_axi_sram_slave;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  logic       aclk = 1'b0;
  logic       areset_n;
  logic [1:0] dbg_wr;
  logic       dbg_rd;

  tvip_axi_sram_slave_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  tvip_axi_sram_slave #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(256)
  ) dut (
    .aclk           (aclk),
    .areset_n       (areset_n),
    .axi            (axi),
    .dbg_wr_state_o (dbg_wr),
    .dbg_rd_state_o (dbg_rd)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [256];
  logic [31:0] wd [32];
  logic [3:0]  ws [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] all_outputs();
    return {axi.awready, axi.wready, axi.bvalid, axi.bid, axi.bresp, axi.arready,
            axi.rvalid, axi.rid, axi.rdata, axi.rresp, axi.rlast, dbg_wr, dbg_rd};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    axi.awvalid = 1'b1; axi.awid = id; axi.awaddr = addr;
    axi.awlen = 8'(len); axi.awsize = size; axi.awburst = burst;
    @(negedge aclk);
    while (!axi.awready && n < 50) begin @(negedge aclk); n++; end
    check("awready", axi.awready, 1);
    @(posedge aclk); #1;
    axi.awvalid = 1'b0;
    check("wready_latency", axi.wready, 1);
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    axi.wvalid = 1'b1; axi.wdata = d; axi.wstrb = s; axi.wlast = l;
    @(negedge aclk);
    while (!axi.wready && n < 50) begin @(negedge aclk); n++; end
    check("wready", axi.wready, 1);
    @(posedge aclk); #1;
    axi.wvalid = 1'b0;
  endtask

  task automatic b_recv(input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    axi.bready = 1'b1;
    @(negedge aclk);
    while (!axi.bvalid && n < 50) begin @(negedge aclk); n++; end
    check("bvalid", axi.bvalid, 1);
    check("bid", axi.bid, id);
    check("bresp", axi.bresp, resp);
    @(posedge aclk); #1;
    axi.bready = 1'b0;
    check("awready_after_b", axi.awready, 1);
  endtask

  // Write burst from wd/ws; flip >= 0 inverts wlast on that beat.
  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int flip);
    logic        err;
    logic        last;
    logic [31:0] a;
    err = (burst == WRAP) || (burst == 2'b11) || (size > 3'd2);
    a   = addr;
    aw_send(id, addr, len, size, burst);
    for (int k = 0; k <= len; k++) begin
      last = (k == len) ^ (k == flip);
      w_beat(wd[k], ws[k], last);
      if (!err)
        for (int b = 0; b < 4; b++)
          if (ws[k][b]) model_mem[a[9:2]][8*b +: 8] = wd[k][8*b +: 8];
      if (last != (k == len)) err = 1'b1;
      if (burst == INCR) a = a + (32'd1 << size);
    end
    check("bvalid_latency", axi.bvalid, 1);
    b_recv(id, err ? 2'b10 : 2'b00);
  endtask

  // Read burst; bp=1 toggles rready 1,0,1,0,... starting with 1.
  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input bit bp);
    logic        err;
    logic [31:0] a;
    int          n = 0;
    int          beat = 0;
    int          cyc = 0;
    err = (burst == WRAP) || (burst == 2'b11) || (size > 3'd2);
    a   = addr;
    for (int k = 0; k <= len; k++) begin
      exp_q.push_back(err ? 32'h0 : model_mem[a[9:2]]);
      if (burst == INCR) a = a + (32'd1 << size);
    end
    axi.arvalid = 1'b1; axi.arid = id; axi.araddr = addr;
    axi.arlen = 8'(len); axi.arsize = size; axi.arburst = burst;
    @(negedge aclk);
    while (!axi.arready && n < 50) begin @(negedge aclk); n++; end
    check("arready", axi.arready, 1);
    @(posedge aclk); #1;
    axi.arvalid = 1'b0;
    check("rvalid_latency", axi.rvalid, 1);
    while (beat <= len && cyc < 200) begin
      axi.rready = bp ? ((cyc % 2) == 0) : 1'b1;
      @(negedge aclk);
      if (axi.rvalid) begin
        check("rdata", axi.rdata, exp_q[0]);
        check("rid", axi.rid, id);
        check("rresp", axi.rresp, err ? 2'b10 : 2'b00);
        check("rlast", axi.rlast, beat == len);
        if (axi.rready) begin
          void'(exp_q.pop_front());
          beat++;
        end
      end
      @(posedge aclk); #1;
      cyc++;
    end
    axi.rready = 1'b0;
    check("r_beat_count", beat, len + 1);
    check("rvalid_done", axi.rvalid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
    axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
    axi.rready = 0;
    areset_n = 1'b1;
    #1 areset_n = 1'b0;
    #2 check("reset_outputs", all_outputs(), 64'h0);
    repeat (3) @(posedge aclk);
    @(negedge aclk) areset_n = 1'b1;
    #1 check("awready_before_edge", axi.awready, 0);
    @(posedge aclk); #1;
    check("awready_after_release", axi.awready, 1);
    check("arready_after_release", axi.arready, 1);

    // Single write/read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    wr_burst(4'd3, 32'h10, 0, 3'd2, INCR, -1);
    rd_burst(4'd3, 32'h10, 0, 3'd2, INCR, 1'b0);

    // INCR burst, read with backpressure
    for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
    wr_burst(4'd1, 32'h40, 3, 3'd2, INCR, -1);
    rd_burst(4'd2, 32'h40, 3, 3'd2, INCR, 1'b1);

    // Byte strobes on a FIXED burst
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    wr_burst(4'd4, 32'h80, 0, 3'd2, INCR, -1);
    wd[0] = 32'h000000AA; ws[0] = 4'h1;
    wd[1] = 32'h00BB0000; ws[1] = 4'h4;
    wr_burst(4'd4, 32'h80, 1, 3'd2, FIXED, -1);
    check("fixed_strobe_model", model_mem[32], 32'hFFBBFFAA);
    rd_burst(4'd5, 32'h80, 0, 3'd2, INCR, 1'b0);

    // Error bursts
    wd[0] = 32'h0; wd[1] = 32'h0; ws[0] = 4'hF; ws[1] = 4'hF;
    wr_burst(4'd6, 32'h80, 1, 3'd2, WRAP, -1);
    rd_burst(4'd6, 32'h80, 0, 3'd2, INCR, 1'b0);
    rd_burst(4'd7, 32'h10, 2, 3'd3, INCR, 1'b0);
    wd[0] = 32'h5; wd[1] = 32'h6;
    wr_burst(4'd8, 32'hC0, 1, 3'd2, INCR, 0);

    // Aliasing: 0x400 maps onto word 0
    wd[0] = 32'h12345678; ws[0] = 4'hF;
    wr_burst(4'd9, 32'h400, 0, 3'd2, INCR, -1);
    rd_burst(4'd9, 32'h0, 0, 3'd2, INCR, 1'b0);

    // Overlapped read/write; each read beat loads on the edge its word is written
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    for (int k = 0; k < 4; k++) ws[k] = 4'hF;
    wr_burst(4'd1, 32'h100, 3, 3'd2, INCR, -1);
    wd[0] = 32'hA1; wd[1] = 32'hA2; wd[2] = 32'hA3;
    fork
      wr_burst(4'd7, 32'h104, 2, 3'd2, INCR, -1);
      rd_burst(4'd8, 32'h100, 3, 3'd2, INCR, 1'b0);
    join
    rd_burst(4'd8, 32'h100, 3, 3'd2, INCR, 1'b0);

    // Random INCR bursts over a pre-filled region
    for (int k = 0; k < 32; k++) begin wd[k] = $urandom(); ws[k] = 4'hF; end
    wr_burst(4'd2, 32'h300, 31, 3'd2, INCR, -1);
    for (int it = 0; it < 4; it++) begin
      int          len;
      logic [31:0] addr;
      len  = $urandom_range(0, 7);
      addr = 32'h300 + 32'(4 * $urandom_range(0, 16));
      for (int k = 0; k <= len; k++) begin wd[k] = $urandom(); ws[k] = 4'($urandom_range(0, 15)); end
      wr_burst(4'($urandom_range(0, 15)), addr, len, 3'd2, INCR, -1);
      rd_burst(4'($urandom_range(0, 15)), addr, len, 3'd2, INCR, it[0]);
    end

    // Reset during beat 2 of a write burst
    aw_send(4'd5, 32'h200, 3, 3'd2, INCR);
    w_beat(32'hC0DE0000, 4'hF, 1'b0);
    model_mem[128] = 32'hC0DE0000;
    w_beat(32'hC0DE0001, 4'hF, 1'b0);
    model_mem[129] = 32'hC0DE0001;
    axi.wvalid = 1'b1; axi.wdata = 32'hC0DE0002; axi.wstrb = 4'hF; axi.wlast = 1'b0;
    #2 areset_n = 1'b0;
    #1 check("midburst_reset_outputs", all_outputs(), 64'h0);
    axi.wvalid = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk) areset_n = 1'b1;
    #1 check("awready_held_low", axi.awready, 0);
    @(posedge aclk); #1;
    check("awready_after_midburst", axi.awready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("no_stale_bvalid", axi.bvalid, 0);
    end
    @(posedge aclk); #1;
    rd_burst(4'd5, 32'h200, 1, 3'd2, INCR, 1'b0);

    // ---------------- final report ----------------
    repeat (2) @(posedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
